// File: rtl/operand_issue_regfile.sv
// operand_issue_regfile
//   Front end for the 4-bit Decode_and_Execute ALU. Instructions are queued
//   in a small FIFO and issued in order: each issue reads both source
//   operands from a 4x4-bit register file into a registered issue stage that
//   drives the combinational ALU. The ALU result (alu_rd) is written back to
//   the destination register on the edge after issue.
//
//   Optional build macro: ISSUE_FORWARD_EN
//     defined   : a head instruction that reads the in-flight destination
//                 issues at once, taking that operand from alu_rd.
//     undefined : such an instruction waits one cycle and then reads the
//                 freshly written register. Architectural results are the
//                 same either way; only timing differs.
//
//   Ports
//     clk, rst_n            clock (rising edge), async active-low reset
//     in_valid/in_ready     instruction input handshake
//     in_instr[8:0]         {op[8:6], dst[5:4], srcs[3:2], srct[1:0]}
//     stall                 inhibit issue (FIFO pop) this cycle
//     alu_valid             issue register holds a live instruction
//     alu_sel/rs/rt         registered operands presented to the ALU
//     alu_rd                ALU result for the current alu_sel/rs/rt
//     ld_en/addr/data       debug register load (idle only)
//     dbg_addr/dbg_data     combinational debug register read
//     busy                  FIFO non-empty or issue register live
//     retired               wrapping count of written-back instructions
//
//   Handshake: an instruction transfers on a rising edge where in_valid and
//   in_ready are both high. in_ready is !full only (never depends on a
//   same-cycle pop); once in_valid is raised, in_instr must stay stable until
//   the transfer edge.

module operand_issue_regfile #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_instr,
  input  logic             stall,
  output logic             alu_valid,
  output logic [2:0]       alu_sel,
  output logic [3:0]       alu_rs,
  output logic [3:0]       alu_rt,
  input  logic [3:0]       alu_rd,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [3:0]       ld_data,
  input  logic [1:0]       dbg_addr,
  output logic [3:0]       dbg_data,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] RET_ONE = CNT_W'(1);

  // FIFO
  logic [8:0]    fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Register file
  logic [3:0] regs_q [4];
  logic [3:0] regs_d [4];

  // Issue register
  logic       alu_valid_q, alu_valid_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] rs_q, rs_d;
  logic [3:0] rt_q, rt_d;
  logic [1:0] dst_q, dst_d;

  logic [CNT_W-1:0] retired_q, retired_d;

  // Head decode
  logic [8:0] head;
  logic [2:0] h_op;
  logic [1:0] h_dst, h_s, h_t;
  logic       full, empty;
  logic       match_s, match_t;
  logic       hz_block;
  logic [3:0] op_s, op_t;
  logic       do_push, do_pop, ld_ok;

  assign head  = fifo_q[rd_ptr_q];
  assign h_op  = head[8:6];
  assign h_dst = head[5:4];
  assign h_s   = head[3:2];
  assign h_t   = head[1:0];

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A source matches the register being written back on this very edge.
  assign match_s = alu_valid_q && (h_s == dst_q);
  assign match_t = alu_valid_q && (h_t == dst_q);

`ifdef ISSUE_FORWARD_EN
  // The register file still holds the old value this cycle; alu_rd is the
  // value that lands in it on the same edge, so take it directly.
  assign hz_block = 1'b0;
  assign op_s     = match_s ? alu_rd : regs_q[h_s];
  assign op_t     = match_t ? alu_rd : regs_q[h_t];
`else
  // Hold the head one cycle so the writeback lands before the read.
  assign hz_block = match_s | match_t;
  assign op_s     = regs_q[h_s];
  assign op_t     = regs_q[h_t];
`endif

  assign do_push = in_valid && !full;
  assign do_pop  = !empty && !stall && !hz_block;

  assign busy  = !empty || alu_valid_q;
  // Debug loads only when nothing is queued, in flight or arriving, so they
  // can never collide with a writeback.
  assign ld_ok = ld_en && !busy && !in_valid;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    alu_valid_d = do_pop;
    sel_d       = sel_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    dst_d       = dst_q;
    retired_d   = retired_q;
    regs_d      = regs_q;

    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (do_pop) begin
      sel_d = h_op;
      rs_d  = op_s;
      rt_d  = op_t;
      dst_d = h_dst;
    end

    if (alu_valid_q) begin
      regs_d[dst_q] = alu_rd;
      retired_d     = retired_q + RET_ONE;
    end else if (ld_ok) begin
      regs_d[ld_addr] = ld_data;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) fifo_q[wr_ptr_q] <= in_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      regs_q      <= '{default: '0};
      alu_valid_q <= 1'b0;
      sel_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      dst_q       <= '0;
      retired_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      regs_q      <= regs_d;
      alu_valid_q <= alu_valid_d;
      sel_q       <= sel_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      dst_q       <= dst_d;
      retired_q   <= retired_d;
    end
  end

  assign in_ready  = !full;
  assign alu_valid = alu_valid_q;
  assign alu_sel   = sel_q;
  assign alu_rs    = rs_q;
  assign alu_rt    = rt_q;
  assign dbg_data  = regs_q[dbg_addr];
  assign retired   = retired_q;

endmodule

// File: tb/tb_operand_issue_regfile.sv
// Testbench for operand_issue_regfile. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled on the falling edge or 1 unit after
// the rising edge. The reference model executes accepted instructions in
// program order on an architectural register array, so expected issue
// operands and final register contents are independent of pipeline timing.

module tb_operand_issue_regfile;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_instr = '0;
  logic       stall = 1'b0;
  logic       alu_valid;
  logic [2:0] alu_sel;
  logic [3:0] alu_rs, alu_rt, alu_rd;
  logic       ld_en = 1'b0;
  logic [1:0] ld_addr = '0;
  logic [3:0] ld_data = '0;
  logic [1:0] dbg_addr = '0;
  logic [3:0] dbg_data;
  logic       busy;
  logic [7:0] retired;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [3:0]  mreg [4];
  logic [10:0] exp_q [$];
  int          n_acc = 0;
  int          n_issued = 0;

  always #5 clk = ~clk;

  operand_issue_regfile #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .stall(stall),
    .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_rs(alu_rs), .alu_rt(alu_rt),
    .alu_rd(alu_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .busy(busy), .retired(retired)
  );

  // Bench ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl1, 6 shr1, 7 pass rs
  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return {a[2:0], 1'b0};
      3'd6:    return {1'b0, a[3:1]};
      default: return a;
    endcase
  endfunction

  always_comb alu_rd = alu_f(alu_sel, alu_rs, alu_rt);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Architectural execution of one accepted instruction.
  task automatic model_push(input logic [8:0] ins);
    logic [2:0] op;
    logic [1:0] d, s, t;
    op = ins[8:6]; d = ins[5:4]; s = ins[3:2]; t = ins[1:0];
    exp_q.push_back({op, mreg[s], mreg[t]});
    mreg[d] = alu_f(op, mreg[s], mreg[t]);
    n_acc++;
  endtask

  // Scoreboard: every live issue cycle consumes one expected instruction.
  always @(negedge clk) begin
    if (rst_n && alu_valid) begin
      n_issued++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL issue_unexpected actual=%0h required=none", {alu_sel, alu_rs, alu_rt});
      end else begin
        check("issue_ops", {21'd0, alu_sel, alu_rs, alu_rt}, {21'd0, exp_q.pop_front()});
      end
    end
  end

  // One cycle with optional instruction offer. Entered and left at posedge+1.
  task automatic step(input logic v, input logic [8:0] ins);
    in_valid = v;
    in_instr = ins;
    @(negedge clk);
    if (v && in_ready) model_push(ins);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_ld(input logic [1:0] a, input logic [3:0] d, input logic taken);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    if (taken) mreg[a] = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < 4; i++) mreg[i] = 4'd0;
    n_acc = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    ld_en = 1'b0;
    stall = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [3:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic check_model_regs(input string name);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      check(name, {28'd0, v}, {28'd0, mreg[i]});
    end
    check("retired_model", {24'd0, retired}, 32'(n_acc % 256));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    stall = 1'b0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_done", {31'd0, exp_q.size() == 0}, 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("drain_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [3:0] r1v;
    logic [3:0] r2v;
    logic [8:0] instr;
    logic [1:0] dst;
    logic [3:0] exp;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    logic [3:0] v;
    logic [3:0] pat;
    logic [3:0] exp_pat;
    int n0;
    int cyc;

    vecs[0] = '{4'h3, 4'h5, 9'b000_00_01_10, 2'd0, 4'h8};
    vecs[1] = '{4'h2, 4'h7, 9'b001_11_01_10, 2'd3, 4'hB};
    vecs[2] = '{4'hC, 4'hA, 9'b010_10_01_10, 2'd2, 4'h8};
    vecs[3] = '{4'hC, 4'h3, 9'b011_00_01_10, 2'd0, 4'hF};
    vecs[4] = '{4'hF, 4'h5, 9'b100_01_01_10, 2'd1, 4'hA};
    vecs[5] = '{4'h9, 4'h1, 9'b101_00_01_10, 2'd0, 4'h2};
    vecs[6] = '{4'h9, 4'h1, 9'b110_00_01_10, 2'd0, 4'h4};
    vecs[7] = '{4'h6, 4'h1, 9'b111_11_01_10, 2'd3, 4'h6};
    vecs[8] = '{4'h7, 4'h2, 9'b000_00_01_01, 2'd0, 4'hE};

    // Reset state
    do_reset();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ops", {21'd0, alu_sel, alu_rs, alu_rt}, 32'd0);
    check("rst_retired", {24'd0, retired}, 32'd0);
    check_model_regs("rst_reg");

    // Idle load, then single ADD with latency checks
    do_ld(2'd1, 4'd3, 1'b1);
    do_ld(2'd2, 4'd5, 1'b1);
    step(1'b1, 9'b000_00_01_10);
    check("t1_not_yet", {31'd0, alu_valid}, 32'd0);
    step(1'b0, 9'd0);
    check("t1_valid", {31'd0, alu_valid}, 32'd1);
    check("t1_ops", {21'd0, alu_sel, alu_rs, alu_rt}, {21'd0, 3'b000, 4'd3, 4'd5});
    step(1'b0, 9'd0);
    check("t1_pulse_end", {31'd0, alu_valid}, 32'd0);
    read_reg(2'd0, v);
    check("t1_reg0", {28'd0, v}, 32'd8);
    check("t1_retired", {24'd0, retired}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back RAW hazard
    do_ld(2'd1, 4'd3, 1'b1);
    do_ld(2'd2, 4'd5, 1'b1);
    step(1'b1, 9'b000_11_01_10);
    step(1'b1, 9'b001_00_11_01);
    pat[3] = alu_valid;
    step(1'b0, 9'd0);
    pat[2] = alu_valid;
    step(1'b0, 9'd0);
    pat[1] = alu_valid;
    step(1'b0, 9'd0);
    pat[0] = alu_valid;
`ifdef ISSUE_FORWARD_EN
    exp_pat = 4'b1100;
`else
    exp_pat = 4'b1010;
`endif
    check("raw_timing", {28'd0, pat}, {28'd0, exp_pat});
    drain();
    read_reg(2'd0, v);
    check("raw_reg0", {28'd0, v}, 32'd5);
    read_reg(2'd3, v);
    check("raw_reg3", {28'd0, v}, 32'd8);
    @(posedge clk);
    #1;

    // FIFO full under stall
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("full_in_ready", {31'd0, in_ready}, (i < 4) ? 32'd1 : 32'd0);
      step(1'b1, {3'(i), 2'(i), 2'(i + 1), 2'(i + 2)});
      check("full_stalled", {31'd0, alu_valid}, 32'd0);
    end
    check("full_ready_low", {31'd0, in_ready}, 32'd0);
    n0 = n_issued;
    drain();
    check("full_issue_count", 32'(n_issued - n0), 32'd4);
    check("full_ready_back", {31'd0, in_ready}, 32'd1);
    check_model_regs("full_reg");

    // Load while busy is ignored, load when idle is taken
    stall = 1'b1;
    step(1'b1, 9'b111_01_00_00);
    check("ldb_busy", {31'd0, busy}, 32'd1);
    do_ld(2'd2, 4'd9, 1'b0);
    read_reg(2'd2, v);
    check("ldb_ignored", {28'd0, v}, {28'd0, mreg[2]});
    drain();
    do_ld(2'd2, 4'd9, 1'b1);
    read_reg(2'd2, v);
    check("ldb_taken", {28'd0, v}, 32'd9);
    @(posedge clk);
    #1;

    // Table-driven single-op vectors
    foreach (vecs[i]) begin
      do_ld(2'd1, vecs[i].r1v, 1'b1);
      do_ld(2'd2, vecs[i].r2v, 1'b1);
      step(1'b1, vecs[i].instr);
      drain();
      read_reg(vecs[i].dst, v);
      check("tbl_result", {28'd0, v}, {28'd0, vecs[i].exp});
      @(posedge clk);
      #1;
    end
    check_model_regs("tbl_reg");

    // Randomized traffic against the model
    for (int i = 0; i < 4; i++) do_ld(2'(i), 4'($urandom_range(0, 15)), 1'b1);
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      step(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)));
    end
    drain();
    check_model_regs("rand_reg");

    // Asynchronous reset mid-stream
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 9'b000_01_10_11);
    stall = 1'b0;
    step(1'b1, 9'b000_01_10_11);
    check("mid_pre_valid", {31'd0, alu_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("mid_alu_valid", {31'd0, alu_valid}, 32'd0);
    check("mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_retired", {24'd0, retired}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      check("mid_reg", {28'd0, v}, 32'd0);
    end
    do_reset();
    check("mid_after_busy", {31'd0, busy}, 32'd0);

    // Retired counter wrap: 256 x AND r0=r0&r0
    do_ld(2'd0, 4'd5, 1'b1);
    cyc = 0;
    while (n_acc < 256 && cyc < 2000) begin
      step(1'b1, 9'b010_00_00_00);
      cyc++;
    end
    check("wrap_accepted", 32'(n_acc), 32'd256);
    drain();
    check("wrap_retired", {24'd0, retired}, 32'd0);
    check_model_regs("wrap_reg");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_issue_regfile.md
Name: operand_issue_regfile

Overview:
- Upstream stage for the 4-bit Decode_and_Execute ALU.
- Buffers incoming instructions in a small FIFO and reads source operands from a 4x4-bit register file.
- Presents registered sel/rs/rt to the combinational ALU, then writes the ALU's rd result back into the register file one cycle later.
- Includes a debug load/read port to seed and inspect registers.

Parameters:
- DEPTH, 4, instruction FIFO depth (power of two, 2..16).
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  FIFO can accept (= !full).
- in_instr  in  9  {op[8:6], dst[5:4], srcs[3:2], srct[1:0]}; op uses the ALU sel encoding 000..111.
- stall  in  1  inhibit issue (FIFO pop) this cycle.
- alu_valid  out  1  issue register holds a live instruction.
- alu_sel  out  3  op of the issued instruction.
- alu_rs  out  4  value of register srcs.
- alu_rt  out  4  value of register srct.
- alu_rd  in  4  ALU result for the current alu_sel/alu_rs/alu_rt.
- ld_en  in  1  debug register load request.
- ld_addr  in  2  debug load address.
- ld_data  in  4  debug load data.
- dbg_addr  in  2  debug read address.
- dbg_data  out  4  combinational read of reg[dbg_addr].
- busy  out  1  FIFO non-empty or alu_valid.
- retired  out  CNT_W  count of written-back instructions.

Behaviour:
- Reset (async, rst_n=0):
  - all regs = 0; FIFO empty; in_ready = 1.
  - alu_valid = 0; alu_sel/alu_rs/alu_rt = 0; retired = 0.
  - Reset mid-operation discards FIFO contents and the in-flight issue; no writeback occurs.
- Push: in_valid & in_ready at a rising edge stores in_instr at the tail.
  - in_ready is combinationally !full; it does not depend on a same-cycle pop.
  - At full, in_valid is ignored.
- Issue: at an edge where the FIFO is non-empty, stall=0 and no hazard stall is active (see Optional Feature):
  - pop the head;
  - load the issue register: alu_sel = op, alu_rs = reg[srcs], alu_rt = reg[srct], dst latched internally;
  - alu_valid = 1 the next cycle.
  - Otherwise alu_valid = 0 the next cycle; alu_sel/rs/rt keep their last values.
- Latency: an instruction pushed at edge N into an empty FIFO is issued at edge N+1 (alu_valid high during cycle N+1..N+2) and written back at edge N+2.
- Throughput: one instruction per cycle.
- Writeback: at every edge where alu_valid = 1:
  - reg[dst] <= alu_rd;
  - retired increments, wrapping 2^CNT_W-1 -> 0.
  - Issue and writeback may occur on the same edge.
- Hazard: the head instruction has srcs or srct equal to the issue-register dst while alu_valid = 1.
- Debug load:
  - ld_en is honoured only when busy = 0 and in_valid = 0: reg[ld_addr] <= ld_data.
  - Otherwise ld_en is ignored and no register changes.
- dbg_data reflects register contents after the last edge (no bypass).
- stall does not affect pushes or a writeback already in flight.

Optional Feature:
- Macro: ISSUE_FORWARD_EN.
- Defined: on a hazard, the issue proceeds without a bubble. The matching operand is taken from alu_rd (the value being written back on that same edge) instead of the register file.
- Undefined: on a hazard, issue is suppressed for one cycle (alu_valid = 0 next cycle). The head issues on the following edge with the updated register value.
- Architectural results are identical in both builds; only timing differs.

Test Plan:
- Idle load, then single ADD:
  - stimulus: ld r1=3, ld r2=5; push ADD dst0,r1,r2 (9'b000_00_01_10); bench ALU model returns rs+rt.
  - required: alu_valid pulses 1 cycle with sel=000, rs=3, rt=5; afterwards dbg reg0 = 8 and retired = 1.
- Back-to-back RAW hazard:
  - stimulus: r1=3, r2=5; push ADD r3=r1+r2 then SUB r0=r3-r1 on consecutive cycles.
  - required with ISSUE_FORWARD_EN: second issue immediately follows with rs=8, rt=3, and reg0 = 5.
  - required without it: exactly one alu_valid=0 bubble, same final reg0 = 5.
- FIFO full:
  - stimulus: stall=1; hold in_valid for 5 cycles with distinct instructions.
  - required: in_ready drops after 4 accepts and the 5th is not taken; release stall → exactly 4 issues in push order, then in_ready = 1.
- Load while busy:
  - stimulus: ld_en with r2=9 while an instruction is queued.
  - required: r2 unchanged; the same ld_en when idle sets r2 = 9.
- Counter wrap and reset:
  - stimulus: issue 256 AND r0=r0&r0 instructions.
  - required: retired reads 0 afterward; rst_n=0 mid-stream clears FIFO, alu_valid, regs and retired immediately without waiting for a clock.
